// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add ops, WIDTH-iteration shift-add multiply
// and bit-serial shifts, with a registered result, zero flag and one-cycle done pulse.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [2:0]       i_select,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;

    typedef enum logic {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_op, w_op_nxt;
    logic [WIDTH-1:0]  r_a, w_a_nxt;
    logic [WIDTH-1:0]  r_b, w_b_nxt;
    logic [WIDTH-1:0]  r_acc, w_acc_nxt;
    logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]  r_result, w_result_nxt;
    logic              r_zero, w_zero_nxt;
    logic              r_done, w_done_nxt;

    logic [31:0]       w_b32;
    logic [CNTW-1:0]   w_amt;
    logic [WIDTH-1:0]  w_acc_sum;

    function automatic logic [WIDTH-1:0] f_single(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        case (op)
            OP_FWD:  res = b;
            OP_ADD:  res = a + b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // Shift amount clamped to WIDTH; shifting WIDTH times yields 0 / sign fill naturally.
    assign w_b32     = 32'(i_data2);
    assign w_amt     = (w_b32 >= 32'(WIDTH)) ? CNTW'(WIDTH) : CNTW'(w_b32);
    assign w_acc_sum = r_acc + (r_b[0] ? r_a : {WIDTH{1'b0}});

    // Next-state and datapath update logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_op_nxt = i_select;
                    case (i_select)
                        OP_MUL: begin
                            w_a_nxt     = i_data1;
                            w_b_nxt     = i_data2;
                            w_acc_nxt   = {WIDTH{1'b0}};
                            w_cnt_nxt   = CNTW'(WIDTH);
                            w_state_nxt = ST_EXEC;
                        end
                        OP_SLL, OP_SRA: begin
                            if (w_amt == {CNTW{1'b0}}) begin
                                w_result_nxt = i_data1;
                                w_done_nxt   = 1'b1;
                            end else begin
                                w_a_nxt     = i_data1;
                                w_cnt_nxt   = w_amt;
                                w_state_nxt = ST_EXEC;
                            end
                        end
                        default: begin
                            w_result_nxt = f_single(i_select, i_data1, i_data2);
                            w_done_nxt   = 1'b1;
                        end
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_cnt_nxt = r_cnt - CNTW'(1);
                case (r_op)
                    OP_MUL: begin
                        w_acc_nxt = w_acc_sum;
                        w_a_nxt   = {r_a[WIDTH-2:0], 1'b0};
                        w_b_nxt   = {1'b0, r_b[WIDTH-1:1]};
                    end
                    OP_SLL:  w_a_nxt = {r_a[WIDTH-2:0], 1'b0};
                    OP_SRA:  w_a_nxt = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
                    default: w_a_nxt = r_a;
                endcase
                // The last iteration edge completes: result, done and return to idle together.
                if (r_cnt == CNTW'(1)) begin
                    w_result_nxt = (r_op == OP_MUL) ? w_acc_sum : w_a_nxt;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_zero_nxt = (w_result_nxt == {WIDTH{1'b0}});
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_op     <= 3'b000;
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_cnt    <= {CNTW{1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_zero   <= w_zero_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_result = r_result;
    assign o_zero   = r_zero;
    assign o_busy   = (r_state == ST_EXEC);
    assign o_done   = r_done;

endmodule
